svk_apb_mem_slave: RTL and testbench

Synthesizable APB4 completer with an internal byte-addressable memory. It sits directly downstream of one `slave[j]` port of the APB interface bundle and is the default responder in VIP self-tests and in system benches where no real peripheral exists. It inserts a programmable number of wait states and returns PSLVERR for misaligned or out-of-window accesses, giving the master VIP a deterministic, protocol-correct target.

---
 rtl/svk_apb_mem_pkg.sv | 23 ++
 rtl/svk_apb_mem_array.sv | 29 ++
 rtl/svk_apb_mem_slave.sv | 156 +++++++++++++++
 tb/tb_svk_apb_mem_slave.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/svk_apb_mem_pkg.sv
// Shared types and decode helper for the APB memory completer.
// Single-edge FSM encoding plus the window/alignment check used at setup.
package svk_apb_mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } svk_apb_mem_state_e;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  // offset is paddr minus base, already wrapped to the address width, so an
  // address below the base shows up as a huge offset and fails the window test.
  function automatic logic svk_apb_addr_err(input logic [63:0] offset,
                                            input logic [63:0] win_bytes,
                                            input int          lane_bits);
    logic [63:0] lane_mask;
    lane_mask = (64'd1 << lane_bits) - 64'd1;
    return ((offset & lane_mask) != 64'd0) || (offset >= win_bytes);
  endfunction

endpackage

// File: rtl/svk_apb_mem_array.sv
// Single-port word RAM with byte enables and combinational read; not reset.
// Write lands on the clock edge, read reflects the indexed word immediately.
module svk_apb_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_W-1:0]     strb_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (strb_i[k]) mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/svk_apb_mem_slave.sv
// APB4 completer over an internal RAM with cfg_wait+1 access cycles per transfer.
// Registered pready/prdata/pslverr; PSLVERR on misaligned or out-of-window access.
module svk_apb_mem_slave
  import svk_apb_mem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    pclk,
  input  logic                    prst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  input  logic [3:0]              cfg_wait,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  output logic                    proto_err
);

  localparam int          STRB_W    = DATA_WIDTH / 8;
  localparam int          LANE_BITS = $clog2(STRB_W);
  localparam int          IDX_W     = $clog2(MEM_DEPTH);
  localparam logic [63:0] WIN_BYTES = 64'(MEM_DEPTH) * 64'(STRB_W);

  svk_apb_mem_state_e    state_q;
  logic [3:0]            wcnt_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_W-1:0]     pstrb_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  err_q;
  logic                  pready_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pslverr_q;
  logic                  proto_err_q;

  logic [ADDR_WIDTH-1:0] offset;
  logic                  addr_bad;
  logic [IDX_W-1:0]      live_idx;
  logic [IDX_W-1:0]      mem_idx;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_we;
  logic                  bad_sel;
  logic                  wr_sel;
  logic                  resp_d;
  logic [DATA_WIDTH-1:0] prdata_d;
  logic                  bus_changed;
  logic                  unused_pprot;

  assign unused_pprot = ^pprot;

  assign offset   = paddr - BASE_ADDR;
  assign addr_bad = svk_apb_addr_err(64'(offset), WIN_BYTES, LANE_BITS);
  assign live_idx = offset[LANE_BITS +: IDX_W];

  // In IDLE the RAM is indexed by the live bus so a zero-wait read can load
  // prdata on the setup edge; otherwise the captured index drives the port.
  assign mem_idx  = (state_q == IDLE) ? live_idx : idx_q;
  assign bad_sel  = (state_q == IDLE) ? addr_bad : err_q;
  assign wr_sel   = (state_q == IDLE) ? pwrite   : pwrite_q;
  assign resp_d   = bad_sel ? RESP_SLVERR : RESP_OKAY;
  assign prdata_d = (bad_sel || wr_sel) ? '0 : mem_rdata;

  assign bus_changed = (paddr != paddr_q) || (pwrite != pwrite_q) ||
                       (pwdata != pwdata_q) || (pstrb != pstrb_q);

  assign mem_we = (state_q == ACCESS) && psel && penable && pready_q &&
                  pwrite_q && (pslverr_q == RESP_OKAY) && !prst;

  svk_apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH)
  ) u_array (
    .clk_i   (pclk),
    .we_i    (mem_we),
    .idx_i   (mem_idx),
    .wdata_i (pwdata_q),
    .strb_i  (pstrb_q),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      pready_q    <= 1'b0;
      prdata_q    <= '0;
      pslverr_q   <= RESP_OKAY;
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (psel && !penable) begin
            paddr_q  <= paddr;
            pwrite_q <= pwrite;
            pwdata_q <= pwdata;
            pstrb_q  <= pstrb;
            idx_q    <= live_idx;
            err_q    <= addr_bad;
            wcnt_q   <= cfg_wait;
            state_q  <= ACCESS;
            if (cfg_wait == 4'd0) begin
              pready_q  <= 1'b1;
              prdata_q  <= prdata_d;
              pslverr_q <= resp_d;
            end
          end else if (psel && penable) begin
            proto_err_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (!psel) begin
            // Master walked away mid-transfer: drop everything, nothing committed.
            proto_err_q <= 1'b1;
            pready_q    <= 1'b0;
            prdata_q    <= '0;
            pslverr_q   <= RESP_OKAY;
            wcnt_q      <= '0;
            state_q     <= IDLE;
          end else begin
            if (bus_changed) proto_err_q <= 1'b1;
            if (penable && pready_q) begin
              pready_q  <= 1'b0;
              prdata_q  <= '0;
              pslverr_q <= RESP_OKAY;
              state_q   <= IDLE;
            end else if (wcnt_q != 4'd0) begin
              wcnt_q <= wcnt_q - 4'd1;
              if (wcnt_q == 4'd1) begin
                pready_q  <= 1'b1;
                prdata_q  <= prdata_d;
                pslverr_q <= resp_d;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pready    = pready_q;
  assign prdata    = prdata_q;
  assign pslverr   = pslverr_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_svk_apb_mem_slave.sv
// Directed bench for svk_apb_mem_slave: one task per scenario, hand-computed expectations.
module tb_svk_apb_mem_slave;

  logic        pclk = 1'b0;
  logic        prst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [3:0]  cfg_wait;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        proto_err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic proto_seen = 1'b0;

  svk_apb_mem_slave dut (
    .pclk      (pclk),
    .prst      (prst),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .pprot     (pprot),
    .cfg_wait  (cfg_wait),
    .pready    (pready),
    .prdata    (prdata),
    .pslverr   (pslverr),
    .proto_err (proto_err)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;
  always @(negedge pclk) if (proto_err) proto_seen = 1'b1;

  // Called at posedge+1; leaves psel high and penable high after completion.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdat,
                          input logic [3:0] strb, input logic [3:0] wt,
                          output logic [31:0] rdat, output logic err, output int ncyc);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = wdat; pstrb = strb; cfg_wait = wt;
    @(posedge pclk); #1;
    penable = 1'b1;
    ncyc = 0; rdat = 'x; err = 1'bx;
    while (1) begin
      ncyc++;
      if (pready) begin
        rdat = prdata; err = pslverr;
        @(posedge pclk); #1;
        break;
      end
      if (ncyc > 40) begin
        n_checks++;
        $display("FAIL xfer_timeout addr=%h got no pready after %0d cycles, want pready", addr, ncyc);
        break;
      end
      @(posedge pclk); #1;
    end
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) begin @(posedge pclk); #1; end
  endtask

  task automatic test_reset();
    prst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; pprot = '0; cfg_wait = '0;
    repeat (3) @(posedge pclk); #1;
    n_checks++; if (pready !== 1'b0) $display("FAIL reset_pready got=%b exp=0", pready); else n_pass++;
    n_checks++; if (prdata !== 32'h0) $display("FAIL reset_prdata got=%h exp=0", prdata); else n_pass++;
    n_checks++; if (pslverr !== 1'b0) $display("FAIL reset_pslverr got=%b exp=0", pslverr); else n_pass++;
    n_checks++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err got=%b exp=0", proto_err); else n_pass++;
    prst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic er; int nc;
    apb_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd0, rd, er, nc);
    n_checks++; if (nc !== 1) $display("FAIL basic_wr_cycles got=%0d exp=1", nc); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL basic_wr_err got=%b exp=0", er); else n_pass++;
    idle(1);
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0, rd, er, nc);
    n_checks++; if (nc !== 1) $display("FAIL basic_rd_cycles got=%0d exp=1", nc); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL basic_rd_data got=%h exp=deadbeef", rd); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL basic_rd_err got=%b exp=0", er); else n_pass++;
    idle(1);
    n_checks++; if (prdata !== 32'h0) $display("FAIL basic_prdata_cleared got=%h exp=0", prdata); else n_pass++;
    // pstrb==0 write is an OKAY no-op
    apb_xfer(1'b1, 32'h10, 32'h0BADF00D, 4'h0, 4'd0, rd, er, nc);
    n_checks++; if (er !== 1'b0) $display("FAIL nostrb_err got=%b exp=0", er); else n_pass++;
    idle(1);
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, 4'd0, rd, er, nc);
    n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL nostrb_rd got=%h exp=deadbeef", rd); else n_pass++;
    idle(1);
  endtask

  task automatic test_partial();
    logic [31:0] rd; logic er; int nc;
    apb_xfer(1'b1, 32'h20, 32'h11223344, 4'hF, 4'd0, rd, er, nc);
    idle(1);
    apb_xfer(1'b1, 32'h20, 32'h000000AA, 4'h1, 4'd3, rd, er, nc);
    n_checks++; if (nc !== 4) $display("FAIL partial_wait_cycles got=%0d exp=4", nc); else n_pass++;
    n_checks++; if (er !== 1'b0) $display("FAIL partial_err got=%b exp=0", er); else n_pass++;
    idle(1);
    apb_xfer(1'b0, 32'h20, 32'h0, 4'h0, 4'd0, rd, er, nc);
    n_checks++; if (rd !== 32'h112233AA) $display("FAIL partial_rd got=%h exp=112233aa", rd); else n_pass++;
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int nc; int c0; int tot;
    proto_seen = 1'b0;
    c0 = cyc;
    apb_xfer(1'b1, 32'h0, 32'h11111111, 4'hF, 4'd0, rd, er, nc);
    apb_xfer(1'b1, 32'h4, 32'h22222222, 4'hF, 4'd0, rd, er, nc);
    apb_xfer(1'b1, 32'h8, 32'h33333333, 4'hF, 4'd0, rd, er, nc);
    tot = cyc - c0;
    n_checks++; if (tot !== 6) $display("FAIL b2b_total_cycles got=%0d exp=6", tot); else n_pass++;
    idle(1);
    n_checks++; if (proto_seen !== 1'b0) $display("FAIL b2b_proto_err got=%b exp=0", proto_seen); else n_pass++;
    apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, 4'd0, rd, er, nc);
    n_checks++; if (rd !== 32'h11111111) $display("FAIL b2b_rd0 got=%h exp=11111111", rd); else n_pass++;
    apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, 4'd0, rd, er, nc);
    n_checks++; if (rd !== 32'h22222222) $display("FAIL b2b_rd4 got=%h exp=22222222", rd); else n_pass++;
    apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, 4'd0, rd, er, nc);
    n_checks++; if (rd !== 32'h33333333) $display("FAIL b2b_rd8 got=%h exp=33333333", rd); else n_pass++;
    idle(1);
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int nc;
    apb_xfer(1'b0, 32'h402, 32'h0, 4'h0, 4'd0, rd, er, nc);
    n_checks++; if (er !== 1'b1) $display("FAIL misalign_err got=%b exp=1", er); else n_pass++;
    n_checks++; if (rd !== 32'h0) $display("FAIL misalign_data got=%h exp=0", rd); else n_pass++;
    idle(1);
    apb_xfer(1'b0, 32'h400, 32'h0, 4'h0, 4'd2, rd, er, nc);
    n_checks++; if (er !== 1'b1) $display("FAIL oow_err got=%b exp=1", er); else n_pass++;
    n_checks++; if (rd !== 32'h0) $display("FAIL oow_data got=%h exp=0", rd); else n_pass++;
    idle(1);
    apb_xfer(1'b1, 32'h400, 32'h12345678, 4'hF, 4'd0, rd, er, nc);
    n_checks++; if (er !== 1'b1) $display("FAIL oow_wr_err got=%b exp=1", er); else n_pass++;
    idle(1);
    apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, 4'd0, rd, er, nc);
    n_checks++; if (rd !== 32'h11111111) $display("FAIL oow_no_alias got=%h exp=11111111", rd); else n_pass++;
    idle(1);
  endtask

  task automatic test_idle_penable();
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0; pstrb = 4'hF;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    n_checks++; if (proto_err !== 1'b1) $display("FAIL idle_penable_proto got=%b exp=1", proto_err); else n_pass++;
    n_checks++; if (pready !== 1'b0) $display("FAIL idle_penable_pready got=%b exp=0", pready); else n_pass++;
    @(posedge pclk); #1;
    n_checks++; if (proto_err !== 1'b0) $display("FAIL idle_penable_pulse got=%b exp=0", proto_err); else n_pass++;
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int nc;
    apb_xfer(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 4'd0, rd, er, nc);
    idle(1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'h55; pstrb = 4'hF; cfg_wait = 4'd5;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    n_checks++; if (proto_err !== 1'b1) $display("FAIL abort_proto got=%b exp=1", proto_err); else n_pass++;
    n_checks++; if (pready !== 1'b0) $display("FAIL abort_pready got=%b exp=0", pready); else n_pass++;
    @(posedge pclk); #1;
    n_checks++; if (proto_err !== 1'b0) $display("FAIL abort_pulse got=%b exp=0", proto_err); else n_pass++;
    apb_xfer(1'b0, 32'h30, 32'h0, 4'h0, 4'd0, rd, er, nc);
    n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL abort_rd got=%h exp=cafef00d", rd); else n_pass++;
    idle(1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int nc;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'h77; pstrb = 4'hF; cfg_wait = 4'd7;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b0; psel = 1'b0; penable = 1'b0;
    n_checks++; if (pready !== 1'b0) $display("FAIL rstmid_pready got=%b exp=0", pready); else n_pass++;
    n_checks++; if (prdata !== 32'h0) $display("FAIL rstmid_prdata got=%h exp=0", prdata); else n_pass++;
    n_checks++; if (pslverr !== 1'b0) $display("FAIL rstmid_pslverr got=%b exp=0", pslverr); else n_pass++;
    n_checks++; if (proto_err !== 1'b0) $display("FAIL rstmid_proto got=%b exp=0", proto_err); else n_pass++;
    @(posedge pclk); #1;
    apb_xfer(1'b0, 32'h30, 32'h0, 4'h0, 4'd0, rd, er, nc);
    n_checks++; if (nc !== 1) $display("FAIL rstmid_idle_cycles got=%0d exp=1", nc); else n_pass++;
    n_checks++; if (rd !== 32'hCAFEF00D) $display("FAIL rstmid_rd got=%h exp=cafef00d", rd); else n_pass++;
    idle(1);
  endtask

  task automatic test_bus_change();
    logic [31:0] rd; logic er; int nc;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40; pwdata = 32'h0BADC0DE; pstrb = 4'hF; cfg_wait = 4'd2;
    @(posedge pclk); #1;
    penable = 1'b1;
    cfg_wait = 4'd9;
    @(posedge pclk); #1;
    pwdata = 32'hFFFFFFFF;
    @(posedge pclk); #1;
    n_checks++; if (proto_err !== 1'b1) $display("FAIL change_proto got=%b exp=1", proto_err); else n_pass++;
    n_checks++; if (pready !== 1'b1) $display("FAIL change_pready got=%b exp=1", pready); else n_pass++;
    @(posedge pclk); #1;
    idle(1);
    apb_xfer(1'b0, 32'h40, 32'h0, 4'h0, 4'd0, rd, er, nc);
    n_checks++; if (rd !== 32'h0BADC0DE) $display("FAIL change_captured got=%h exp=0badc0de", rd); else n_pass++;
    idle(1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_back_to_back();
    test_errors();
    test_idle_penable();
    test_abort();
    test_reset_mid();
    test_bus_change();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
